// File: rtl/simd_ctrl_v2.sv
// simd_ctrl_v2 -- instruction sequencer for an N-PE SIMD matrix-multiply array.
//
// Accepts one 32-bit instruction at a time (VALID/READY handshake, ready only
// while idle) and drives the per-PE control lines and register-file row
// addresses that load operands, run a K-step multiply-accumulate and store
// results. Every output is a register; an accepted instruction shows its
// effect on the cycle after acceptance.
//
// Ports
//   CLK          in   clock, rising edge
//   RSTN         in   synchronous active-low reset
//   INSTR[31:0]  in   [2:0] opcode, [3 +: LOGN] row index, [31] broadcast
//   INSTR_VALID  in   instruction offered
//   INSTR_READY  out  high only in IDLE
//   MAC_EN[N]    out  per-PE accumulate enable
//   RST_MUL[N]   out  per-PE accumulator clear
//   WRITE_MAT[N] out  per-PE operand write strobe
//   MAT_MUX[N]   out  per-PE operand source (1 = A row)
//   MATAB_MUX    out  regfile bank select (0 = B, 1 = A)
//   DOUT_MUX     out  route results into C regfile
//   SEQ_A/B/C    out  row addresses (LOGN bits each)
//   K_CNT        out  current MAC step (LOGK bits)
//   DONE         out  one-cycle op-complete pulse
//   ERR          out  sticky illegal-instruction flag
//   HALTED       out  halted until reset
module simd_ctrl_v2 #(
    parameter int N    = 16,
    parameter int K    = 16,
    parameter int LOGN = $clog2(N),
    parameter int LOGK = $clog2(K)
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [31:0]     INSTR,
    input  logic            INSTR_VALID,
    output logic            INSTR_READY,
    output logic [N-1:0]    MAC_EN,
    output logic [N-1:0]    RST_MUL,
    output logic [N-1:0]    WRITE_MAT,
    output logic [N-1:0]    MAT_MUX,
    output logic            MATAB_MUX,
    output logic            DOUT_MUX,
    output logic [LOGN-1:0] SEQ_A,
    output logic [LOGN-1:0] SEQ_B,
    output logic [LOGN-1:0] SEQ_C,
    output logic [LOGK-1:0] K_CNT,
    output logic            DONE,
    output logic            ERR,
    output logic            HALTED
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MAC   = 3'd2,
        S_STORE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LDB   = 3'd1;
    localparam logic [2:0] OP_LDA   = 3'd2;
    localparam logic [2:0] OP_MMUL  = 3'd3;
    localparam logic [2:0] OP_STORE = 3'd4;
    localparam logic [2:0] OP_HALT  = 3'd5;

    localparam logic [N-1:0]    ALL_ONES = {N{1'b1}};
    localparam logic [N-1:0]    ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [LOGK-1:0] K_LAST   = LOGK'(K - 1);
    // Step before the last one: seeing it means the next cycle carries DONE.
    localparam logic [LOGK-1:0] K_PENULT = LOGK'(K - 2);

    state_t            r_state;
    logic              r_ready;
    logic [N-1:0]      r_mac_en;
    logic [N-1:0]      r_rst_mul;
    logic [N-1:0]      r_write_mat;
    logic [N-1:0]      r_mat_mux;
    logic              r_matab_mux;
    logic              r_dout_mux;
    logic [LOGN-1:0]   r_seq_a;
    logic [LOGN-1:0]   r_seq_b;
    logic [LOGN-1:0]   r_seq_c;
    logic [LOGK-1:0]   r_k_cnt;
    logic              r_done;
    logic              r_err;
    logic              r_halted;

    logic [2:0]        w_op;
    logic [LOGN-1:0]   w_idx;
    logic              w_bcast;
    logic              w_is_load;
    logic              w_idx_bad;
    logic              w_illegal;
    logic [N-1:0]      w_onehot;
    logic              w_unused;

    assign w_op      = INSTR[2:0];
    assign w_idx     = INSTR[3 +: LOGN];
    assign w_bcast   = INSTR[31];
    assign w_is_load = (w_op == OP_LDB) || (w_op == OP_LDA);
    // The index only addresses a row for loads; other opcodes ignore it.
    assign w_idx_bad = w_is_load && ({1'b0, w_idx} >= (LOGN + 1)'(N));
    assign w_illegal = (w_op > OP_HALT) || w_idx_bad;
    assign w_onehot  = ONE << w_idx;
    assign w_unused  = &{1'b0, INSTR};

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_mac_en    <= '0;
            r_rst_mul   <= ALL_ONES;
            r_write_mat <= '0;
            r_mat_mux   <= '0;
            r_matab_mux <= 1'b1;
            r_dout_mux  <= 1'b0;
            r_seq_a     <= '0;
            r_seq_b     <= '0;
            r_seq_c     <= '0;
            r_k_cnt     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            // Strobes default low; each state below re-asserts what it grants.
            r_done      <= 1'b0;
            r_mac_en    <= '0;
            r_write_mat <= '0;
            r_mat_mux   <= '0;
            r_dout_mux  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (INSTR_VALID) begin
                        if (w_illegal) begin
                            // Consumed but otherwise a no-op apart from ERR.
                            r_err <= 1'b1;
                        end else begin
                            case (w_op)
                                OP_NOP: begin
                                    r_done <= 1'b1;
                                end
                                OP_LDB: begin
                                    r_state     <= S_LOAD;
                                    r_ready     <= 1'b0;
                                    r_rst_mul   <= '0;
                                    r_matab_mux <= 1'b0;
                                    r_seq_b     <= w_idx;
                                    r_write_mat <= w_bcast ? ALL_ONES : w_onehot;
                                    r_done      <= 1'b1;
                                end
                                OP_LDA: begin
                                    r_state     <= S_LOAD;
                                    r_ready     <= 1'b0;
                                    r_rst_mul   <= '0;
                                    r_matab_mux <= 1'b1;
                                    r_seq_a     <= w_idx;
                                    r_seq_c     <= w_idx;
                                    r_mat_mux   <= ALL_ONES;
                                    r_write_mat <= ALL_ONES;
                                    r_done      <= 1'b1;
                                end
                                OP_MMUL: begin
                                    r_state   <= S_MAC;
                                    r_ready   <= 1'b0;
                                    r_rst_mul <= '0;
                                    r_mac_en  <= ALL_ONES;
                                    r_k_cnt   <= '0;
                                end
                                OP_STORE: begin
                                    r_state    <= S_STORE;
                                    r_ready    <= 1'b0;
                                    r_rst_mul  <= ALL_ONES;
                                    r_dout_mux <= 1'b1;
                                    r_done     <= 1'b1;
                                end
                                default: begin
                                    r_state   <= S_HALT;
                                    r_ready   <= 1'b0;
                                    r_rst_mul <= '0;
                                    r_halted  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_MAC: begin
                    if (r_k_cnt == K_LAST) begin
                        r_state   <= S_IDLE;
                        r_ready   <= 1'b1;
                        r_rst_mul <= ALL_ONES;
                        r_k_cnt   <= '0;
                    end else begin
                        r_mac_en <= ALL_ONES;
                        r_k_cnt  <= r_k_cnt + 1'b1;
                        r_done   <= (r_k_cnt == K_PENULT);
                    end
                end
                S_LOAD, S_STORE: begin
                    r_state   <= S_IDLE;
                    r_ready   <= 1'b1;
                    r_rst_mul <= ALL_ONES;
                end
                default: begin
                    // HALT: only reset leaves this state.
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign INSTR_READY = r_ready;
    assign MAC_EN      = r_mac_en;
    assign RST_MUL     = r_rst_mul;
    assign WRITE_MAT   = r_write_mat;
    assign MAT_MUX     = r_mat_mux;
    assign MATAB_MUX   = r_matab_mux;
    assign DOUT_MUX    = r_dout_mux;
    assign SEQ_A       = r_seq_a;
    assign SEQ_B       = r_seq_b;
    assign SEQ_C       = r_seq_c;
    assign K_CNT       = r_k_cnt;
    assign DONE        = r_done;
    assign ERR         = r_err;
    assign HALTED      = r_halted;

endmodule

// File: tb/tb_simd_ctrl_v2.sv
// Directed bench for simd_ctrl_v2 with N=16, K=16.
module tb_simd_ctrl_v2;

    localparam int N = 16;
    localparam int K = 16;

    logic        CLK;
    logic        RSTN;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [N-1:0] MAC_EN;
    logic [N-1:0] RST_MUL;
    logic [N-1:0] WRITE_MAT;
    logic [N-1:0] MAT_MUX;
    logic        MATAB_MUX;
    logic        DOUT_MUX;
    logic [3:0]  SEQ_A;
    logic [3:0]  SEQ_B;
    logic [3:0]  SEQ_C;
    logic [3:0]  K_CNT;
    logic        DONE;
    logic        ERR;
    logic        HALTED;

    int n_chk = 0;
    int n_err = 0;

    simd_ctrl_v2 #(.N(N), .K(K)) dut (
        .CLK(CLK), .RSTN(RSTN), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .MAC_EN(MAC_EN), .RST_MUL(RST_MUL),
        .WRITE_MAT(WRITE_MAT), .MAT_MUX(MAT_MUX), .MATAB_MUX(MATAB_MUX),
        .DOUT_MUX(DOUT_MUX), .SEQ_A(SEQ_A), .SEQ_B(SEQ_B), .SEQ_C(SEQ_C),
        .K_CNT(K_CNT), .DONE(DONE), .ERR(ERR), .HALTED(HALTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; sampling and driving happen 1ns after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one instruction for exactly one accepting edge.
    task automatic issue(input logic [31:0] ins);
        INSTR       = ins;
        INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        INSTR       = 32'h0;
    endtask

    initial begin
        RSTN        = 1'b0;
        INSTR       = 32'h0;
        INSTR_VALID = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready",   32'(INSTR_READY), 32'd1);
        chk("rst_rstmul",  32'(RST_MUL),     32'hFFFF);
        chk("rst_matab",   32'(MATAB_MUX),   32'd1);
        chk("rst_macen",   32'(MAC_EN),      32'd0);
        chk("rst_wmat",    32'(WRITE_MAT),   32'd0);
        chk("rst_kcnt",    32'(K_CNT),       32'd0);
        chk("rst_flags",   32'({DONE, ERR, HALTED, DOUT_MUX}), 32'd0);
        chk("rst_seq",     32'({SEQ_A, SEQ_B, SEQ_C}), 32'd0);

        RSTN = 1'b1;
        tick();

        // LDB idx 5
        issue(32'h0000_0029);
        chk("ldb_wmat",    32'(WRITE_MAT),   32'h0020);
        chk("ldb_seqb",    32'(SEQ_B),       32'd5);
        chk("ldb_matab",   32'(MATAB_MUX),   32'd0);
        chk("ldb_matmux",  32'(MAT_MUX),     32'd0);
        chk("ldb_done",    32'(DONE),        32'd1);
        chk("ldb_ready",   32'(INSTR_READY), 32'd0);
        chk("ldb_rstmul",  32'(RST_MUL),     32'd0);
        tick();
        chk("ldb_ready2",  32'(INSTR_READY), 32'd1);
        chk("ldb_done2",   32'(DONE),        32'd0);
        chk("ldb_wmat2",   32'(WRITE_MAT),   32'd0);
        chk("ldb_rstmul2", 32'(RST_MUL),     32'hFFFF);

        // LDB idx 3 broadcast
        issue(32'h8000_0019);
        chk("ldbb_wmat",   32'(WRITE_MAT),   32'hFFFF);
        chk("ldbb_seqb",   32'(SEQ_B),       32'd3);
        tick();
        chk("ldbb_wmat2",  32'(WRITE_MAT),   32'd0);

        // LDA idx 7
        issue(32'h0000_003A);
        chk("lda_seqa",    32'(SEQ_A),       32'd7);
        chk("lda_seqc",    32'(SEQ_C),       32'd7);
        chk("lda_matmux",  32'(MAT_MUX),     32'hFFFF);
        chk("lda_wmat",    32'(WRITE_MAT),   32'hFFFF);
        chk("lda_matab",   32'(MATAB_MUX),   32'd1);
        chk("lda_done",    32'(DONE),        32'd1);
        chk("lda_seqb",    32'(SEQ_B),       32'd3);
        tick();

        // MMUL: 16 MAC cycles
        issue(32'h0000_0003);
        for (int i = 0; i < K; i++) begin
            chk($sformatf("mac_en%0d", i),   32'(MAC_EN),      32'hFFFF);
            chk($sformatf("mac_k%0d", i),    32'(K_CNT),       32'(i));
            chk($sformatf("mac_done%0d", i), 32'(DONE),        (i == K - 1) ? 32'd1 : 32'd0);
            chk($sformatf("mac_rdy%0d", i),  32'(INSTR_READY), 32'd0);
            tick();
        end
        chk("mac_end_en",   32'(MAC_EN),      32'd0);
        chk("mac_end_k",    32'(K_CNT),       32'd0);
        chk("mac_end_rdy",  32'(INSTR_READY), 32'd1);
        chk("mac_end_done", 32'(DONE),        32'd0);

        // STORE
        issue(32'h0000_0004);
        chk("st_dout",     32'(DOUT_MUX),    32'd1);
        chk("st_seqc",     32'(SEQ_C),       32'd7);
        chk("st_rstmul",   32'(RST_MUL),     32'hFFFF);
        chk("st_done",     32'(DONE),        32'd1);
        chk("st_ready",    32'(INSTR_READY), 32'd0);
        tick();
        chk("st_dout2",    32'(DOUT_MUX),    32'd0);
        chk("st_ready2",   32'(INSTR_READY), 32'd1);

        // NOP
        issue(32'h0000_0000);
        chk("nop_done",    32'(DONE),        32'd1);
        chk("nop_ready",   32'(INSTR_READY), 32'd1);
        tick();
        chk("nop_done2",   32'(DONE),        32'd0);

        // Illegal opcode 6
        issue(32'h0000_0006);
        chk("ill_err",     32'(ERR),         32'd1);
        chk("ill_ready",   32'(INSTR_READY), 32'd1);
        chk("ill_done",    32'(DONE),        32'd0);
        chk("ill_seqa",    32'(SEQ_A),       32'd7);
        chk("ill_matab",   32'(MATAB_MUX),   32'd1);
        tick();
        tick();
        chk("ill_err_sticky", 32'(ERR),      32'd1);
        issue(32'h0000_0012);
        chk("ill_lda_seqa", 32'(SEQ_A),      32'd2);
        chk("ill_lda_wmat", 32'(WRITE_MAT),  32'hFFFF);
        chk("ill_lda_done", 32'(DONE),       32'd1);
        chk("ill_lda_err",  32'(ERR),        32'd1);
        tick();

        // Reset in the middle of MAC
        issue(32'h0000_0003);
        for (int i = 0; i < 8; i++) tick();
        chk("mrst_k8",     32'(K_CNT),       32'd8);
        RSTN = 1'b0;
        tick();
        chk("mrst_macen",  32'(MAC_EN),      32'd0);
        chk("mrst_k",      32'(K_CNT),       32'd0);
        chk("mrst_done",   32'(DONE),        32'd0);
        chk("mrst_ready",  32'(INSTR_READY), 32'd1);
        chk("mrst_err",    32'(ERR),         32'd0);
        RSTN = 1'b1;
        tick();
        chk("mrst_done2",  32'(DONE),        32'd0);

        // HALT
        issue(32'h0000_0005);
        chk("halt_halted", 32'(HALTED),      32'd1);
        chk("halt_ready",  32'(INSTR_READY), 32'd0);
        chk("halt_rstmul", 32'(RST_MUL),     32'd0);
        INSTR       = 32'h0000_0029;
        INSTR_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("halt_rdy%0d", i), 32'(INSTR_READY), 32'd0);
            chk($sformatf("halt_h%0d", i),   32'(HALTED),      32'd1);
            chk($sformatf("halt_w%0d", i),   32'(WRITE_MAT),   32'd0);
        end
        INSTR_VALID = 1'b0;
        INSTR       = 32'h0;
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        chk("halt_rst_ready",  32'(INSTR_READY), 32'd1);
        chk("halt_rst_halted", 32'(HALTED),      32'd0);
        chk("halt_rst_done",   32'(DONE),        32'd0);
        tick();
        chk("halt_rst_ready2", 32'(INSTR_READY), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/simd_ctrl_v2.md
SIMD_CTRL_V2 -- requirements
Module: simd_ctrl_v2

Interface
REQ-001 SHALL have parameter N, default 16, number of PEs (2..64).
REQ-002 SHALL have parameter K, default 16, MAC cycles per MMUL (2..256).
REQ-003 SHALL use derived widths LOGN=$clog2(N), LOGK=$clog2(K).
REQ-004 SHALL have port CLK  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port RSTN  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port INSTR  in  32  instruction: [2:0] opcode, [3+:LOGN] index, [31] broadcast flag.
REQ-007 SHALL have port INSTR_VALID  in  1  instruction offered.
REQ-008 SHALL have port INSTR_READY  out  1  instruction accepted when VALID&&READY.
REQ-009 SHALL have port MAC_EN  out  N  per-PE accumulate enable.
REQ-010 SHALL have port RST_MUL  out  N  per-PE accumulator clear.
REQ-011 SHALL have port WRITE_MAT  out  N  per-PE operand write.
REQ-012 SHALL have port MAT_MUX  out  N  per-PE operand source select (1 = A row).
REQ-013 SHALL have port MATAB_MUX  out  1  regfile bank select (0 = B, 1 = A).
REQ-014 SHALL have port DOUT_MUX  out  1  result path to C regfile.
REQ-015 SHALL have ports SEQ_A, SEQ_B, SEQ_C  out  LOGN each  row addresses.
REQ-016 SHALL have port K_CNT  out  LOGK  current MAC step.
REQ-017 SHALL have ports DONE, ERR, HALTED  out  1 each  op-complete pulse, sticky error, halted.

Function
REQ-018 SHALL decode opcodes 0 NOP, 1 LDB, 2 LDA, 3 MMUL, 4 STORE, 5 HALT; 6-7 illegal.
REQ-019 SHALL implement FSM states IDLE, LOAD, MAC, STORE, HALT; INSTR_READY=1 only in IDLE.
REQ-020 SHALL, on acceptance in IDLE: LDB/LDA -> LOAD, MMUL -> MAC, STORE -> STORE, HALT -> HALT, NOP -> stay IDLE.
REQ-021 SHALL drive all outputs registered; the effect of an accepted instruction appears on the cycle after acceptance.
REQ-022 SHALL hold LOAD exactly 1 cycle, then return to IDLE.
REQ-023 SHALL, in LOAD for LDB: MATAB_MUX=0, SEQ_B=index, MAT_MUX=0, WRITE_MAT=one-hot(index), or all ones if INSTR[31]=1.
REQ-024 SHALL, in LOAD for LDA: MATAB_MUX=1, SEQ_A=index, MAT_MUX=all ones, WRITE_MAT=all ones, SEQ_C<=index.
REQ-025 SHALL hold MAC exactly K cycles: MAC_EN=all ones, K_CNT counting 0..K-1, then return to IDLE with K_CNT=0.
REQ-026 SHALL hold STORE exactly 1 cycle with DOUT_MUX=1, SEQ_C unchanged, RST_MUL=all ones.
REQ-027 SHALL assert RST_MUL=all ones in IDLE and STORE and zero in LOAD, MAC and HALT.
REQ-028 SHALL drive MAC_EN, WRITE_MAT, MAT_MUX and DOUT_MUX to 0 in every state not granting them.
REQ-029 SHALL hold SEQ_A, SEQ_B and SEQ_C at their last written value; no high-impedance output.
REQ-030 SHALL pulse DONE for 1 cycle on the last cycle of LOAD, MAC (K_CNT=K-1) and STORE, and on the cycle after accepting a NOP.
REQ-031 SHALL, on an illegal opcode or index>=N, set ERR (sticky until reset), consume the instruction, stay in IDLE, and leave all other outputs unchanged.
REQ-032 SHALL, in HALT, set HALTED=1 and INSTR_READY=0 and ignore INSTR_VALID until reset.
REQ-033 SHALL ignore INSTR and INSTR_VALID in every state except IDLE.

Reset
REQ-034 SHALL, while RSTN=0 at a clock edge, enter IDLE with INSTR_READY=1, RST_MUL=all ones, MATAB_MUX=1, all other outputs 0 and K_CNT=0.
REQ-035 SHALL, on reset asserted mid-MAC or in HALT, abort the operation immediately and produce no DONE pulse.

Verification
REQ-036 SHALL cover (N=16,K=16): LDB idx 5 -> next cycle WRITE_MAT=0x0020, SEQ_B=5, MATAB_MUX=0, DONE=1, READY=1 one cycle later.
REQ-037 SHALL cover: LDB idx 3 with INSTR[31]=1 -> WRITE_MAT=0xFFFF for 1 cycle.
REQ-038 SHALL cover: LDA idx 7 then MMUL -> SEQ_C=7, MAC_EN=0xFFFF for exactly 16 cycles, DONE only at K_CNT=15, then STORE gives DOUT_MUX=1, SEQ_C=7.
REQ-039 SHALL cover: opcode 6 -> ERR=1 persisting, FSM in IDLE; subsequent LDA executes normally.
REQ-040 SHALL cover: RSTN=0 at K_CNT=8 -> next cycle IDLE, MAC_EN=0, K_CNT=0, no DONE.
REQ-041 SHALL cover: HALT -> HALTED=1, READY=0 for 20 cycles with VALID=1; RSTN pulse restores READY=1.
